sipo_byte_capture: RTL and testbench

- Receive end of the parallel-in/serial-out pixel/data shift path: deserialises the MSB-first bit stream produced by a PISO shifter and its active-low shift/load strobe.
- Rebuilds each word, latches it into a held output register with a one-cycle valid strobe, and flags framing errors.
- Sits between a PISO serial output and downstream parallel logic (compare/latch stages, test capture) in the FPGA TTL-equivalent video and data path.

---
 rtl/sipo_byte_capture.sv | 79 +++++++
 tb/tb_sipo_byte_capture.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_byte_capture.sv
// Serial-in/parallel-out receiver for an MSB-first PISO stream framed by an
// active-low load strobe; holds each completed word and flags aborted words.
module sipo_byte_capture #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                       clk1,
  input  logic                       n_clr1,
  input  logic                       ser_in,
  input  logic                       n_load,
  input  logic                       clk_inh,
  output logic [WIDTH-1:0]           shift_q,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic                       frame_err,
  output logic                       busy,
  output logic [$clog2(WIDTH):0]     bit_cnt,
  output logic [CNT_W-1:0]           word_cnt
);

  localparam int BC_W = $clog2(WIDTH) + 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  logic             state;
  logic [WIDTH-1:0] next_shift;

  assign next_shift = {shift_q[WIDTH-2:0], ser_in};
  // state is itself a flop, so busy stays a registered output
  assign busy = (state == ST_SHIFT);

  // NOTE: every register here uses non-blocking assignment so all updates
  // within one edge see the pre-edge values, matching real flip-flops.
  always_ff @(posedge clk1 or negedge n_clr1) begin
    if (!n_clr1) begin
      state     <= ST_IDLE;
      shift_q   <= '0;
      q         <= '0;
      q_valid   <= 1'b0;
      frame_err <= 1'b0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
    end else begin
      // Strobes default low so they last exactly one cycle, including when inhibited
      q_valid   <= 1'b0;
      frame_err <= 1'b0;
      if (!clk_inh) begin
        case (state)
          ST_IDLE: begin
            if (!n_load) begin
              state   <= ST_SHIFT;
              bit_cnt <= '0;
            end
          end
          default: begin
            if (bit_cnt == LAST_BIT) begin
              // Final bit: complete the word; a simultaneous load re-arms without error
              shift_q  <= next_shift;
              q        <= next_shift;
              q_valid  <= 1'b1;
              word_cnt <= word_cnt + CNT_W'(1);
              bit_cnt  <= '0;
              state    <= n_load ? ST_IDLE : ST_SHIFT;
            end else if (!n_load) begin
              frame_err <= 1'b1;
              bit_cnt   <= '0;
            end else begin
              shift_q <= next_shift;
              bit_cnt <= bit_cnt + BC_W'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sipo_byte_capture.sv
// Randomised and directed bench for sipo_byte_capture; a bit-queue model
// predicts every output and is compared against the DUT on each falling edge.
module tb_sipo_byte_capture;

  localparam int W = 8;

  logic         clk1 = 1'b0;
  logic         n_clr1;
  logic         ser_in;
  logic         n_load;
  logic         clk_inh;
  logic [W-1:0] shift_q;
  logic [W-1:0] q;
  logic         q_valid;
  logic         frame_err;
  logic         busy;
  logic [3:0]   bit_cnt;
  logic [7:0]   word_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  sipo_byte_capture #(.WIDTH(W), .CNT_W(8)) dut (
    .clk1      (clk1),
    .n_clr1    (n_clr1),
    .ser_in    (ser_in),
    .n_load    (n_load),
    .clk_inh   (clk_inh),
    .shift_q   (shift_q),
    .q         (q),
    .q_valid   (q_valid),
    .frame_err (frame_err),
    .busy      (busy),
    .bit_cnt   (bit_cnt),
    .word_cnt  (word_cnt)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the current word is a queue of received bits
  bit      m_armed;
  int      m_bits[$];
  int      m_shift, m_q, m_words;
  bit      m_valid, m_err;

  always @(posedge clk1 or negedge n_clr1) begin
    if (!n_clr1) begin
      m_armed = 0; m_bits.delete(); m_shift = 0; m_q = 0;
      m_words = 0; m_valid = 0; m_err = 0;
    end else begin
      m_valid = 0;
      m_err   = 0;
      if (!clk_inh) begin
        if (!m_armed) begin
          if (!n_load) begin
            m_armed = 1;
            m_bits.delete();
          end
        end else if (m_bits.size() == W - 1) begin
          int w;
          m_bits.push_back(int'(ser_in));
          m_shift = (m_shift * 2 + int'(ser_in)) % (1 << W);
          w = 0;
          foreach (m_bits[i]) w = w * 2 + m_bits[i];
          m_q     = w;
          m_valid = 1;
          m_words = (m_words + 1) % 256;
          m_bits.delete();
          m_armed = !n_load;
        end else if (!n_load) begin
          m_err = 1;
          m_bits.delete();
        end else begin
          m_bits.push_back(int'(ser_in));
          m_shift = (m_shift * 2 + int'(ser_in)) % (1 << W);
        end
      end
    end
  end

  always @(negedge clk1) begin
    if (chk_en) begin
      check("shift_q",   32'(shift_q),   32'(m_shift));
      check("q",         32'(q),         32'(m_q));
      check("q_valid",   32'(q_valid),   32'(m_valid));
      check("frame_err", 32'(frame_err), 32'(m_err));
      check("busy",      32'(busy),      32'(m_armed));
      check("bit_cnt",   32'(bit_cnt),   32'(m_bits.size()));
      check("word_cnt",  32'(word_cnt),  32'(m_words));
      if (q_valid && frame_err) check("strobe_excl", 32'(1), 32'(0));
    end
  end

  task automatic drive(input logic nl, input logic si, input logic inh);
    @(negedge clk1);
    n_load  = nl;
    ser_in  = si;
    clk_inh = inh;
  endtask

  // Shift a word MSB first; rearm pulls n_load low on the final bit
  task automatic send_word(input logic [W-1:0] w, input logic rearm);
    for (int i = W - 1; i >= 0; i--)
      drive((i == 0) ? !rearm : 1'b1, w[i], 1'b0);
  endtask

  task automatic after_edge();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk1);
    #2 n_clr1 = 1'b0;
    @(negedge clk1);
    n_clr1 = 1'b1;
  endtask

  initial begin
    logic [W-1:0] w;
    n_clr1 = 1'b0; ser_in = 1'b0; n_load = 1'b1; clk_inh = 1'b0;
    repeat (2) @(negedge clk1);
    check("rst_q",        32'(q),        32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    check("rst_word_cnt", 32'(word_cnt), 32'h0);
    n_clr1 = 1'b1;
    chk_en = 1'b1;

    // Single word
    drive(1'b0, 1'b0, 1'b0);
    send_word(8'hA5, 1'b0);
    after_edge();
    check("t1_q",        32'(q),        32'hA5);
    check("t1_q_valid",  32'(q_valid),  32'h1);
    check("t1_word_cnt", 32'(word_cnt), 32'h1);
    check("t1_busy",     32'(busy),     32'h0);

    // Back-to-back
    drive(1'b0, 1'b0, 1'b0);
    send_word(8'h3C, 1'b1);
    after_edge();
    check("t2_q0",    32'(q),    32'h3C);
    check("t2_busy0", 32'(busy), 32'h1);
    send_word(8'hC3, 1'b0);
    after_edge();
    check("t2_q1",        32'(q),        32'hC3);
    check("t2_word_cnt",  32'(word_cnt), 32'h3);

    // Premature reload
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    after_edge();
    check("t3_frame_err", 32'(frame_err), 32'h1);
    check("t3_q_held",    32'(q),         32'hC3);
    check("t3_bit_cnt",   32'(bit_cnt),   32'h0);
    send_word(8'h81, 1'b0);
    after_edge();
    check("t3_q",       32'(q),       32'h81);
    check("t3_q_valid", 32'(q_valid), 32'h1);

    // Inhibit mid-word, with a load pulse that must be ignored
    w = 8'h5A;
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 7; i >= 4; i--) drive(1'b1, w[i], 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    after_edge();
    check("t4_bit_cnt",   32'(bit_cnt),   32'h4);
    check("t4_shift_q",   32'(shift_q[3:0]), 32'h5);
    check("t4_frame_err", 32'(frame_err), 32'h0);
    for (int i = 3; i >= 0; i--) drive(1'b1, w[i], 1'b0);
    after_edge();
    check("t4_q", 32'(q), 32'h5A);

    // Asynchronous reset between edges, mid-word
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0);
    after_edge();
    #1 n_clr1 = 1'b0;
    #1;
    check("t5_q",        32'(q),        32'h0);
    check("t5_shift_q",  32'(shift_q),  32'h0);
    check("t5_bit_cnt",  32'(bit_cnt),  32'h0);
    check("t5_word_cnt", 32'(word_cnt), 32'h0);
    check("t5_busy",     32'(busy),     32'h0);
    @(negedge clk1);
    n_clr1 = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    send_word(8'hFF, 1'b0);
    after_edge();
    check("t5_q_ff", 32'(q), 32'hFF);

    // 256 streamed words wrap the counter
    do_reset();
    drive(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 256; k++)
      send_word(W'($urandom_range(0, 255)), k != 255);
    after_edge();
    check("t6_q_valid",  32'(q_valid),  32'h1);
    check("t6_word_cnt", 32'(word_cnt), 32'h0);

    // Random traffic
    for (int k = 0; k < 3000; k++)
      drive($urandom_range(0, 5) != 0, 1'($urandom), $urandom_range(0, 9) == 0);

    @(negedge clk1);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
